// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
//   arb_state_e        : sequencer states (IDLE, SEND, GAP)
//   DEF_NUM_REQ        : default requester count
//   ID_W               : grant index width for the default requester count
//   DEF_TIMEOUT_CYCLES : default watchdog limit in clock cycles
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ        = 4;
  localparam int unsigned ID_W               = $clog2(DEF_NUM_REQ);
  localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd2000000;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational rotate-priority encoder.
//   req         : request mask, one bit per requester
//   rr_ptr      : highest-priority index when unlocked
//   lock, owner : when lock=1 only owner may win
//   gnt_valid_c : a winner exists
//   gnt_idx_c   : index of the winner
module uart_rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  input  logic                       lock,
  input  logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       gnt_valid_c,
  output logic [$clog2(NUM_REQ)-1:0] gnt_idx_c
);

  localparam int unsigned GNT_W = $clog2(NUM_REQ);

  // Search rr_ptr, rr_ptr+1, ... modulo NUM_REQ; first hit wins.
  always_comb begin
    int unsigned idx;
    idx         = 0;
    gnt_valid_c = 1'b0;
    gnt_idx_c   = '0;
    if (lock) begin
      gnt_valid_c = req[owner];
      gnt_idx_c   = owner;
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = 32'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!gnt_valid_c && req[GNT_W'(idx)]) begin
          gnt_valid_c = 1'b1;
          gnt_idx_c   = GNT_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte-stream requesters.
// Round-robin grant held for a whole packet, tx_start/clear_req handshake,
// and a watchdog that aborts a frame the transmitter never completes.
//   clk, rst                         : clock, async active-high reset
//   req_valid/req_data/req_last      : per-requester byte offer
//   req_ready                        : same-cycle accept pulse (one-hot)
//   tx_start, tx_data, clear_req     : transmitter handshake
//   busy, grant_id, err_timeout      : status
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       clear_req,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       err_timeout
);

  localparam int unsigned GNT_W = $clog2(NUM_REQ);

  arb_state_e       state_q, state_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             last_q, last_d;
  logic [GNT_W-1:0] grant_id_q, grant_id_d;
  logic [GNT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [31:0]      timer_q, timer_d;
  logic             err_timeout_q, err_timeout_d;
  logic             busy_q, busy_d;

  logic             gnt_valid;
  logic [GNT_W-1:0] gnt_idx;
  logic [GNT_W-1:0] next_id;
  logic             timeout_hit;

  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req         (req_valid),
    .rr_ptr      (rr_ptr_q),
    .lock        (lock_q),
    .owner       (grant_id_q),
    .gnt_valid_c (gnt_valid),
    .gnt_idx_c   (gnt_idx)
  );

  // Requester after the current owner, wrapping to 0.
  assign next_id = (grant_id_q == GNT_W'(NUM_REQ - 1)) ? '0 : grant_id_q + GNT_W'(1);

  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (timer_q == TIMEOUT_CYCLES - 32'd1);

  // Next-state and datapath updates.
  always_comb begin
    state_d       = state_q;
    tx_start_d    = tx_start_q;
    tx_data_d     = tx_data_q;
    last_d        = last_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    lock_d        = lock_q;
    timer_d       = timer_q;
    err_timeout_d = 1'b0;
    req_ready     = '0;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          tx_data_d          = req_data[{gnt_idx, 3'b000} +: 8];
          last_d             = req_last[gnt_idx];
          grant_id_d         = gnt_idx;
          req_ready[gnt_idx] = 1'b1;
          tx_start_d         = 1'b1;
          timer_d            = '0;
          state_d            = SEND;
        end
      end
      SEND: begin
        // Completion takes priority over a simultaneous watchdog expiry.
        if (clear_req) begin
          tx_start_d = 1'b0;
          state_d    = GAP;
          if (last_q) begin
            lock_d   = 1'b0;
            rr_ptr_d = next_id;
          end else begin
            lock_d   = 1'b1;
          end
        end else if (timeout_hit) begin
          tx_start_d    = 1'b0;
          err_timeout_d = 1'b1;
          lock_d        = 1'b0;
          rr_ptr_d      = next_id;
          state_d       = GAP;
        end else begin
          timer_d = (timer_q == '1) ? timer_q : timer_q + 32'd1;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        tx_start_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE) || lock_d;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      last_q        <= 1'b0;
      grant_id_q    <= '0;
      rr_ptr_q      <= '0;
      lock_q        <= 1'b0;
      timer_q       <= '0;
      err_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      last_q        <= last_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      lock_q        <= lock_d;
      timer_q       <= timer_d;
      err_timeout_q <= err_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign err_timeout = err_timeout_q;
  assign busy        = busy_q;

endmodule
